// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target block and the CPU-side I2C
// controller: the target FSM state type, the default bus address and the
// bus-level ACK/NACK bit values.
//
// Contents:
//   i2c_state_e          - target FSM states
//   DEFAULT_TARGET_ADDR  - 7-bit address the target answers to by default
//   ACK / NACK           - SDA level of an acknowledge / not-acknowledge bit
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } i2c_state_e;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h42;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings the raw SCL/SDA bus levels into the CLK domain and decodes the bus
// events the target FSM works from. Each line goes through a two-flop
// synchronizer followed by one history flop; every edge decision is made on
// the synchronized value versus its history.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   scl_i      in   raw SCL level (asynchronous)
//   sda_i      in   raw SDA level (asynchronous)
//   sda_s      out  synchronized SDA level, used for bit sampling
//   scl_rise   out  one-CLK strobe, SCL went low -> high
//   scl_fall   out  one-CLK strobe, SCL went high -> low
//   start_det  out  one-CLK strobe, SDA fell while SCL held high
//   stop_det   out  one-CLK strobe, SDA rose while SCL held high
// ---------------------------------------------------------------------------
module i2c_line_sync (
    input  logic CLK,
    input  logic RST,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] r_sclSync;
    logic [1:0] r_sdaSync;
    logic       r_sclPrev;
    logic       r_sdaPrev;

    // Synchronizer and history flops. They reset to the idle-bus level (both
    // lines high) so that leaving reset never looks like an edge or START.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[0], scl_i};
            r_sdaSync <= {r_sdaSync[0], sda_i};
            r_sclPrev <= r_sclSync[1];
            r_sdaPrev <= r_sdaSync[1];
        end
    end

    // Event decode. START/STOP need SCL high in both the current and the
    // previous sample so an SDA change racing an SCL edge is not mistaken
    // for a bus condition.
    assign sda_s     = r_sdaSync[1];
    assign scl_rise  =  r_sclSync[1] & ~r_sclPrev;
    assign scl_fall  = ~r_sclSync[1] &  r_sclPrev;
    assign start_det =  r_sclSync[1] &  r_sclPrev & r_sdaPrev & ~r_sdaSync[1];
    assign stop_det  =  r_sclSync[1] &  r_sclPrev & ~r_sdaPrev & r_sdaSync[1];

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
// I2C target (slave) with a small byte-wide register file shared with a
// host port. A bus write sends the address, then a register pointer, then
// any number of data bytes (pointer auto-increments with wrap). A bus read
// returns bytes starting at the current pointer, again auto-incrementing
// for as long as the master ACKs. A repeated START keeps the pointer, so
// "write pointer, repeated START, read" works as expected.
//
// Build option:
//   I2C_TARGET_GCALL_EN  when defined, address 7'h00 with W is ACKed and
//                        handled exactly like a write to TARGET_ADDR;
//                        general-call reads are NACKed. When undefined,
//                        7'h00 is an ordinary non-matching address.
//
// Parameters:
//   TARGET_ADDR  7-bit bus address (default 7'h42)
//   NREGS        register-file depth, power of two, 2..256
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   scl_i       in   raw SCL level
//   sda_i       in   raw SDA level
//   sda_oe      out  1 pulls SDA low (open-drain pad)
//   host_addr   in   host register index
//   host_rdata  out  regs[host_addr], combinational
//   host_we     in   host write strobe
//   host_wdata  in   host write data
//   wr_pulse    out  one-CLK pulse after each bus-written byte
//   wr_index    out  index of the most recent bus-written byte
//   busy        out  high from an address match until STOP or next START
// ---------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int         NREGS       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    input  logic [$clog2(NREGS)-1:0] host_addr,
    output logic [7:0]               host_rdata,
    input  logic                     host_we,
    input  logic [7:0]               host_wdata,
    output logic                     wr_pulse,
    output logic [$clog2(NREGS)-1:0] wr_index,
    output logic                     busy
);

    localparam int PW = $clog2(NREGS);

    i2c_state_e    r_state;
    i2c_state_e    w_nextState;

    logic [7:0]    r_regs [NREGS];
    logic [7:0]    r_shift;
    logic [7:0]    r_txShift;
    logic [3:0]    r_bitCnt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_wrIndex;
    logic          r_wrPulse;
    logic          r_busy;
    logic          r_ackBit;

    logic          w_sda;
    logic          w_sclRise;
    logic          w_sclFall;
    logic          w_start;
    logic          w_stop;
    logic          w_byteEnd;
    logic          w_addrHit;
    logic          w_gcallWrite;
    logic          w_addrAccept;
    logic          w_busWrite;
    logic [7:0]    w_busData;
    logic [PW-1:0] w_ptrInc;

    i2c_line_sync u_lineSync (
        .CLK       (CLK),
        .RST       (RST),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_s     (w_sda),
        .scl_rise  (w_sclRise),
        .scl_fall  (w_sclFall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    // A byte is complete on the SCL fall that follows its 8th rise; that
    // fall is where the FSM steps into the matching ACK state.
    assign w_byteEnd = w_sclFall && (r_bitCnt == 4'd8);
    assign w_ptrInc  = r_ptr + PW'(1);

    // Address decode looks at the full received address byte in r_shift.
    assign w_addrHit = (r_shift[7:1] == TARGET_ADDR);
`ifdef I2C_TARGET_GCALL_EN
    assign w_gcallWrite = (r_shift[7:1] == 7'h00) && !r_shift[0];
`else
    assign w_gcallWrite = 1'b0;
`endif
    assign w_addrAccept = w_addrHit || w_gcallWrite;

    // The data byte is committed on its 8th SCL rise, so the last bit comes
    // straight from the line rather than from the shift register.
    assign w_busWrite = (r_state == WDATA) && w_sclRise && (r_bitCnt == 4'd7);
    assign w_busData  = {r_shift[6:0], w_sda};

    // State register. Reset drops straight to IDLE, which also releases SDA
    // immediately because sda_oe is decoded from this register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. START and STOP override whatever the FSM is doing;
    // everything else advances only on SCL falls, so SDA ownership changes
    // exclusively while SCL is low.
    always_comb begin
        w_nextState = r_state;
        if (w_start) begin
            w_nextState = ADDR;
        end else if (w_stop) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:      w_nextState = IDLE;
                ADDR:      if (w_byteEnd) w_nextState = w_addrAccept ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (w_sclFall) w_nextState = r_shift[0] ? RDATA : PTR;
                PTR:       if (w_byteEnd) w_nextState = PTR_ACK;
                PTR_ACK:   if (w_sclFall) w_nextState = WDATA;
                WDATA:     if (w_byteEnd) w_nextState = WDATA_ACK;
                WDATA_ACK: if (w_sclFall) w_nextState = WDATA;
                RDATA:     if (w_byteEnd) w_nextState = RDATA_ACK;
                RDATA_ACK: if (w_sclFall) w_nextState = (r_ackBit == NACK) ? IGNORE : RDATA;
                IGNORE:    w_nextState = IGNORE;
                default:   w_nextState = IDLE;
            endcase
        end
    end

    // Output decode. We pull SDA low for our own ACK bits and for the zero
    // bits of a byte being read; in every other state SDA is released.
    always_comb begin
        sda_oe = 1'b0;
        case (r_state)
            ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe = 1'b1;
            RDATA:                        sda_oe = ~r_txShift[7];
            default:                      sda_oe = 1'b0;
        endcase
    end

    assign busy       = r_busy;
    assign wr_pulse   = r_wrPulse;
    assign wr_index   = r_wrIndex;
    assign host_rdata = r_regs[host_addr];

    // Bit-level datapath: receive shifting, bit counting, pointer updates,
    // transmit shift register and the master's ACK sample. The pointer is
    // deliberately untouched by START/STOP so it survives a repeated START.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift   <= '0;
            r_txShift <= '0;
            r_bitCnt  <= '0;
            r_ptr     <= '0;
            r_wrIndex <= '0;
            r_wrPulse <= 1'b0;
            r_busy    <= 1'b0;
            r_ackBit  <= NACK;
        end else begin
            r_wrPulse <= w_busWrite;
            if (w_busWrite) begin
                r_wrIndex <= r_ptr;
            end
            if (w_start || w_stop) begin
                r_bitCnt <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR, WDATA: begin
                        if (w_sclRise) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                        if (w_byteEnd) begin
                            r_bitCnt <= '0;
                        end
                        if ((r_state == ADDR) && w_byteEnd && w_addrAccept) begin
                            r_busy <= 1'b1;
                        end
                        if ((r_state == PTR) && w_byteEnd) begin
                            r_ptr <= r_shift[PW-1:0];
                        end
                        if (w_busWrite) begin
                            r_ptr <= w_ptrInc;
                        end
                    end
                    ADDR_ACK: begin
                        if (w_sclFall && r_shift[0]) begin
                            r_txShift <= r_regs[r_ptr];
                        end
                    end
                    RDATA: begin
                        if (w_sclRise) begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                        if (w_sclFall) begin
                            if (r_bitCnt == 4'd8) begin
                                r_bitCnt <= '0;
                            end else begin
                                r_txShift <= {r_txShift[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (w_sclRise) begin
                            r_ackBit <= w_sda;
                        end
                        if (w_sclFall && (r_ackBit == ACK)) begin
                            r_ptr     <= w_ptrInc;
                            r_txShift <= r_regs[w_ptrInc];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Register file. The bus write is placed after the host write so that
    // when both hit the same index in one cycle, the bus byte is what lands.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (host_we) begin
                r_regs[host_addr] <= host_wdata;
            end
            if (w_busWrite) begin
                r_regs[r_ptr] <= w_busData;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
// Bench for i2c_target: acts as the I2C master on an open-drain SDA line and
// as the host on the register port. Honours I2C_TARGET_GCALL_EN for the
// general-call expectations.
// ---------------------------------------------------------------------------
module tb_i2c_target;

    localparam int NREGS = 16;
    localparam int PW    = 4;
    localparam int QCYC  = 10;

    typedef struct {
        logic [7:0]    ptrByte;
        logic [7:0]    data;
        logic [2:0]    expAcks;
        logic [PW-1:0] expIndex;
    } wrVec_t;

    logic          CLK        = 1'b0;
    logic          RST        = 1'b0;
    logic          sclM       = 1'b1;
    logic          sdaM       = 1'b1;
    logic          host_we    = 1'b0;
    logic [PW-1:0] host_addr  = '0;
    logic [7:0]    host_wdata = '0;
    logic          sdaLine;
    logic          sda_oe;
    logic [7:0]    host_rdata;
    logic          wr_pulse;
    logic [PW-1:0] wr_index;
    logic          busy;

    int checks     = 0;
    int errors     = 0;
    int pulseCount = 0;
    int oeCount    = 0;
    int busyCount  = 0;

    // Open-drain bus: the line is low if either side pulls it low.
    assign sdaLine = sdaM & ~sda_oe;

    i2c_target #(
        .TARGET_ADDR (7'h42),
        .NREGS       (NREGS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .scl_i      (sclM),
        .sda_i      (sdaLine),
        .sda_oe     (sda_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .host_we    (host_we),
        .host_wdata (host_wdata),
        .wr_pulse   (wr_pulse),
        .wr_index   (wr_index),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Running tallies of DUT activity, sampled away from the active edge.
    always @(negedge CLK) begin
        if (wr_pulse) pulseCount++;
        if (sda_oe)   oeCount++;
        if (busy)     busyCount++;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        repeat (60000) @(posedge CLK);
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitQ();
        repeat (QCYC) @(negedge CLK);
    endtask

    task automatic i2cStart();
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b0; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic i2cStop();
        sdaM = 1'b0; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b1; waitQ();
    endtask

    task automatic writeBit(input logic b);
        sdaM = b;    waitQ();
        sclM = 1'b1; waitQ(); waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        b = sdaLine; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(data[i]);
        readBit(ack);
    endtask

    task automatic readByte(input logic masterAckBit, output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            data[i] = b;
        end
        writeBit(masterAckBit);
    endtask

    task automatic hostWrite(input logic [PW-1:0] idx, input logic [7:0] data);
        host_addr  = idx;
        host_wdata = data;
        host_we    = 1'b1;
        @(negedge CLK);
        host_we    = 1'b0;
        @(negedge CLK);
    endtask

    task automatic readHost(input logic [PW-1:0] idx, output logic [7:0] data);
        host_addr = idx;
        @(negedge CLK);
        data = host_rdata;
    endtask

    // One complete single-byte write transaction to address 0x42.
    task automatic applyStimulus(input wrVec_t v, output logic [2:0] acks);
        logic a0, a1, a2;
        i2cStart();
        writeByte(8'h84, a2);
        writeByte(v.ptrByte, a1);
        writeByte(v.data, a0);
        i2cStop();
        waitQ();
        acks = {a2, a1, a0};
    endtask

    initial begin
        wrVec_t     vecs [5];
        logic [2:0] acks;
        logic [7:0] rd, rd2;
        logic       a0, a1, a2, a3, a4;
        logic       collPulse;
        int         p0, oe0, b0;

        vecs[0] = '{ptrByte: 8'h03, data: 8'hA5, expAcks: 3'b000, expIndex: 4'd3};
        vecs[1] = '{ptrByte: 8'h0F, data: 8'h11, expAcks: 3'b000, expIndex: 4'd15};
        vecs[2] = '{ptrByte: 8'h00, data: 8'h22, expAcks: 3'b000, expIndex: 4'd0};
        vecs[3] = '{ptrByte: 8'h17, data: 8'h3C, expAcks: 3'b000, expIndex: 4'd7};
        vecs[4] = '{ptrByte: 8'hFA, data: 8'hFF, expAcks: 3'b000, expIndex: 4'd10};

        // Reset state
        repeat (5) @(negedge CLK);
        checkOutput("reset sda_oe", sda_oe, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset wr_pulse", wr_pulse, 1'b0);
        checkOutput("reset wr_index", wr_index, 4'd0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        readHost(4'd3, rd);
        checkOutput("reset regs[3]", rd, 8'h00);

        // Table of single-byte writes, including pointer values beyond NREGS
        for (int i = 0; i < 5; i++) begin
            p0 = pulseCount;
            applyStimulus(vecs[i], acks);
            checkOutput($sformatf("vec%0d acks", i), acks, vecs[i].expAcks);
            checkOutput($sformatf("vec%0d pulses", i), pulseCount - p0, 1);
            checkOutput($sformatf("vec%0d wr_index", i), wr_index, vecs[i].expIndex);
            readHost(vecs[i].expIndex, rd);
            checkOutput($sformatf("vec%0d reg", i), rd, vecs[i].data);
        end

        // Burst write across the top of the register file
        p0 = pulseCount;
        i2cStart();
        writeByte(8'h84, a0);
        writeByte(8'h0F, a1);
        writeByte(8'hAA, a2);
        writeByte(8'hBB, a3);
        i2cStop();
        waitQ();
        checkOutput("burst write acks", {a0, a1, a2, a3}, 4'b0000);
        checkOutput("burst write pulses", pulseCount - p0, 2);
        checkOutput("burst write wr_index", wr_index, 4'd0);
        readHost(4'd15, rd);
        checkOutput("burst write regs[15]", rd, 8'hAA);
        readHost(4'd0, rd);
        checkOutput("burst write regs[0]", rd, 8'hBB);

        // Burst read with wrap via repeated START
        hostWrite(4'd15, 8'h11);
        hostWrite(4'd0, 8'h22);
        i2cStart();
        writeByte(8'h84, a0);
        writeByte(8'h0F, a1);
        i2cStart();
        writeByte(8'h85, a2);
        readByte(1'b0, rd);
        readByte(1'b1, rd2);
        checkOutput("read acks", {a0, a1, a2}, 3'b000);
        checkOutput("read byte0", rd, 8'h11);
        checkOutput("read byte1", rd2, 8'h22);
        waitQ();
        checkOutput("read release after NACK", sda_oe, 1'b0);
        checkOutput("read busy before STOP", busy, 1'b1);
        i2cStop();
        waitQ();
        checkOutput("read busy after STOP", busy, 1'b0);

        // Pointer retained after the NACKed read
        i2cStart();
        writeByte(8'h85, a0);
        readByte(1'b1, rd);
        i2cStop();
        waitQ();
        checkOutput("retained ptr ack", a0, 1'b0);
        checkOutput("retained ptr data", rd, 8'h22);

        // Address mismatch
        p0  = pulseCount;
        oe0 = oeCount;
        b0  = busyCount;
        i2cStart();
        writeByte(8'h86, a0);
        writeByte(8'h5A, a1);
        i2cStop();
        waitQ();
        checkOutput("mismatch acks", {a0, a1}, 2'b11);
        checkOutput("mismatch sda_oe cycles", oeCount - oe0, 0);
        checkOutput("mismatch busy cycles", busyCount - b0, 0);
        checkOutput("mismatch pulses", pulseCount - p0, 0);

        // STOP after four data bits
        p0 = pulseCount;
        i2cStart();
        writeByte(8'h84, a0);
        writeByte(8'h05, a1);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b1);
        i2cStop();
        waitQ();
        checkOutput("abort acks", {a0, a1}, 2'b00);
        checkOutput("abort pulses", pulseCount - p0, 0);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort sda_oe", sda_oe, 1'b0);
        readHost(4'd5, rd);
        checkOutput("abort regs[5]", rd, 8'h00);

        // Bus write of 0x99 and host write of 0x55 to index 2 in the same CLK
        i2cStart();
        writeByte(8'h84, a0);
        writeByte(8'h02, a1);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b0);
        sdaM = 1'b1;
        waitQ();
        sclM = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        host_addr  = 4'd2;
        host_wdata = 8'h55;
        host_we    = 1'b1;
        @(negedge CLK);
        host_we    = 1'b0;
        collPulse  = wr_pulse;
        waitQ();
        sclM = 1'b0;
        waitQ();
        readBit(a2);
        i2cStop();
        waitQ();
        checkOutput("collision acks", {a0, a1, a2}, 3'b000);
        checkOutput("collision same cycle", collPulse, 1'b1);
        checkOutput("collision wr_index", wr_index, 4'd2);
        readHost(4'd2, rd);
        checkOutput("collision regs[2]", rd, 8'h99);

        // General call
        p0 = pulseCount;
        i2cStart();
        writeByte(8'h00, a0);
        writeByte(8'h01, a1);
        writeByte(8'h7E, a2);
        i2cStop();
        waitQ();
        readHost(4'd1, rd);
`ifdef I2C_TARGET_GCALL_EN
        checkOutput("gcall acks", {a0, a1, a2}, 3'b000);
        checkOutput("gcall regs[1]", rd, 8'h7E);
        checkOutput("gcall pulses", pulseCount - p0, 1);
`else
        checkOutput("gcall acks", {a0, a1, a2}, 3'b111);
        checkOutput("gcall regs[1]", rd, 8'h00);
        checkOutput("gcall pulses", pulseCount - p0, 0);
`endif

        // Reset asserted while the target is driving an address ACK
        p0 = pulseCount;
        i2cStart();
        for (int i = 7; i >= 0; i--) writeBit(i == 7 || i == 2);
        sdaM = 1'b1;
        waitQ();
        sclM = 1'b1;
        waitQ();
        checkOutput("mid-reset ack driven", sda_oe, 1'b1);
        RST = 1'b0;
        #1;
        checkOutput("mid-reset sda released", sda_oe, 1'b0);
        checkOutput("mid-reset busy", busy, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        readHost(4'd3, rd);
        checkOutput("mid-reset regs[3] cleared", rd, 8'h00);
        waitQ();
        sclM = 1'b0;
        waitQ();
        writeByte(8'h03, a0);
        writeByte(8'hA5, a1);
        i2cStop();
        waitQ();
        checkOutput("post-reset ignored acks", {a0, a1}, 2'b11);
        checkOutput("post-reset ignored pulses", pulseCount - p0, 0);

        // Fresh transaction after reset
        i2cStart();
        writeByte(8'h84, a0);
        writeByte(8'h04, a1);
        writeByte(8'h66, a4);
        i2cStop();
        waitQ();
        readHost(4'd4, rd);
        checkOutput("post-reset write acks", {a0, a1, a4}, 3'b000);
        checkOutput("post-reset regs[4]", rd, 8'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
